// File: rtl/gpio_cmd_ctrl.sv
// Command controller between the processor GPIO pair and the Tx/Rx/BER/log-memory datapath.
// Decodes strobed opcodes, drives datapath controls and returns status, BER counts or memory words.
module gpio_cmd_ctrl #(
  parameter int NB_GPIOS        = 32,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NB_BER          = 64,
  parameter int RST_CYCLES      = 4,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       i_resetn,
  input  logic [NB_GPIOS-1:0]        i_gpo,
  output logic [NB_GPIOS-1:0]        o_gpi,
  output logic                       o_rst,
  output logic                       o_enb_tx,
  output logic                       o_enb_rx,
  output logic [1:0]                 o_phase_sel,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  input  logic [BRAM_DATA_WIDTH-1:0] i_mem_data,
  input  logic                       i_mem_full,
  input  logic [NB_BER-1:0]          i_ber_samp_i,
  input  logic [NB_BER-1:0]          i_ber_samp_q,
  input  logic [NB_BER-1:0]          i_ber_err_i,
  input  logic [NB_BER-1:0]          i_ber_err_q
);

  // state      | meaning
  // IDLE       | waiting for a strobe edge, decodes opcodes
  // RST_PULSE  | holding o_rst high, down-counting RST_CYCLES
  // MEM_WAIT   | waiting MEM_LATENCY clocks for log-memory read data
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RST_PULSE = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT  = 2'd2;

  localparam logic [7:0] OP_RESET    = 8'd0;
  localparam logic [7:0] OP_EN_TX    = 8'd1;
  localparam logic [7:0] OP_EN_RX    = 8'd2;
  localparam logic [7:0] OP_PH_SEL   = 8'd3;
  localparam logic [7:0] OP_RUN_MEM  = 8'd4;
  localparam logic [7:0] OP_READ_MEM = 8'd5;
  localparam logic [7:0] OP_ADDR_MEM = 8'd6;
  localparam logic [7:0] OP_BER_S_I  = 8'd7;
  localparam logic [7:0] OP_BER_S_Q  = 8'd8;
  localparam logic [7:0] OP_BER_E_I  = 8'd9;
  localparam logic [7:0] OP_BER_E_Q  = 8'd10;
  localparam logic [7:0] OP_BER_H    = 8'd11;
  localparam logic [7:0] OP_MEM_FULL = 8'd12;

  localparam int CNT_W = 8;

  logic [1:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       strb_q, strb_d;
  logic                       arm_q, arm_d;
  logic [NB_GPIOS-1:0]        gpi_q, gpi_d;
  logic                       rst_q, rst_d;
  logic                       enb_tx_q, enb_tx_d;
  logic                       enb_rx_q, enb_rx_d;
  logic [1:0]                 phase_q, phase_d;
  logic                       run_log_q, run_log_d;
  logic                       read_log_q, read_log_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB_BER-1:0]          sh_samp_i_q, sh_samp_i_d;
  logic [NB_BER-1:0]          sh_samp_q_q, sh_samp_q_d;
  logic [NB_BER-1:0]          sh_err_i_q, sh_err_i_d;
  logic [NB_BER-1:0]          sh_err_q_q, sh_err_q_d;
  logic [31:0]                high_q, high_d;

  logic       cmd_edge;
  logic [7:0] opcode;
  logic [22:0] data;

  assign opcode = i_gpo[31:24];
  assign data   = i_gpo[22:0];
  // arm_q blocks a strobe that was already high while reset was asserted
  assign cmd_edge = i_gpo[23] & ~strb_q & arm_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strb_d      = i_gpo[23];
    arm_d       = 1'b1;
    gpi_d       = gpi_q;
    rst_d       = rst_q;
    enb_tx_d    = enb_tx_q;
    enb_rx_d    = enb_rx_q;
    phase_d     = phase_q;
    run_log_d   = 1'b0;
    read_log_d  = read_log_q;
    addr_d      = addr_q;
    sh_samp_i_d = sh_samp_i_q;
    sh_samp_q_d = sh_samp_q_q;
    sh_err_i_d  = sh_err_i_q;
    sh_err_q_d  = sh_err_q_q;
    high_d      = high_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_edge) begin
          case (opcode)
            OP_RESET: begin
              rst_d      = 1'b1;
              cnt_d      = CNT_W'(RST_CYCLES - 1);
              state_d    = ST_RST_PULSE;
              enb_tx_d   = 1'b0;
              enb_rx_d   = 1'b0;
              phase_d    = 2'd0;
              read_log_d = 1'b0;
            end
            OP_EN_TX:    enb_tx_d   = data[0];
            OP_EN_RX:    enb_rx_d   = data[0];
            OP_PH_SEL:   phase_d    = data[1:0];
            OP_RUN_MEM:  run_log_d  = 1'b1;
            OP_READ_MEM: read_log_d = data[0];
            OP_ADDR_MEM: begin
              addr_d  = data[BRAM_ADDR_WIDTH-1:0];
              cnt_d   = CNT_W'(MEM_LATENCY);
              state_d = ST_MEM_WAIT;
            end
            OP_BER_S_I: begin
              sh_samp_i_d = i_ber_samp_i;
              sh_samp_q_d = i_ber_samp_q;
              sh_err_i_d  = i_ber_err_i;
              sh_err_q_d  = i_ber_err_q;
              gpi_d       = i_ber_samp_i[31:0];
              high_d      = 32'(i_ber_samp_i >> 32);
            end
            OP_BER_S_Q: begin
              gpi_d  = sh_samp_q_q[31:0];
              high_d = 32'(sh_samp_q_q >> 32);
            end
            OP_BER_E_I: begin
              gpi_d  = sh_err_i_q[31:0];
              high_d = 32'(sh_err_i_q >> 32);
            end
            OP_BER_E_Q: begin
              gpi_d  = sh_err_q_q[31:0];
              high_d = 32'(sh_err_q_q >> 32);
            end
            OP_BER_H:    gpi_d = high_q;
            OP_MEM_FULL: gpi_d = {{(NB_GPIOS-1){1'b0}}, i_mem_full};
            default: ;
          endcase
        end
      end
      ST_RST_PULSE: begin
        if (cnt_q == '0) begin
          rst_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q == '0) begin
          gpi_d   = {{(NB_GPIOS-BRAM_DATA_WIDTH){1'b0}}, i_mem_data};
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      strb_q      <= 1'b0;
      arm_q       <= 1'b0;
      gpi_q       <= '0;
      rst_q       <= 1'b1;
      enb_tx_q    <= 1'b0;
      enb_rx_q    <= 1'b0;
      phase_q     <= 2'd0;
      run_log_q   <= 1'b0;
      read_log_q  <= 1'b0;
      addr_q      <= '0;
      sh_samp_i_q <= '0;
      sh_samp_q_q <= '0;
      sh_err_i_q  <= '0;
      sh_err_q_q  <= '0;
      high_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strb_q      <= strb_d;
      arm_q       <= arm_d;
      gpi_q       <= gpi_d;
      rst_q       <= rst_d;
      enb_tx_q    <= enb_tx_d;
      enb_rx_q    <= enb_rx_d;
      phase_q     <= phase_d;
      run_log_q   <= run_log_d;
      read_log_q  <= read_log_d;
      addr_q      <= addr_d;
      sh_samp_i_q <= sh_samp_i_d;
      sh_samp_q_q <= sh_samp_q_d;
      sh_err_i_q  <= sh_err_i_d;
      sh_err_q_q  <= sh_err_q_d;
      high_q      <= high_d;
    end
  end

  assign o_gpi       = gpi_q;
  assign o_rst       = rst_q;
  assign o_enb_tx    = enb_tx_q;
  assign o_enb_rx    = enb_rx_q;
  assign o_phase_sel = phase_q;
  assign o_run_log   = run_log_q;
  assign o_read_log  = read_log_q;
  assign o_addr_log  = addr_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Scoreboard bench for gpio_cmd_ctrl: stimulus queues expected outputs with a due cycle,
// a negedge monitor pops and compares them.
module tb_gpio_cmd_ctrl;
  logic        clk = 1'b0;
  logic        i_resetn;
  logic [31:0] i_gpo;
  logic [31:0] o_gpi;
  logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
  logic [1:0]  o_phase_sel;
  logic [14:0] o_addr_log;
  logic [15:0] i_mem_data;
  logic        i_mem_full;
  logic [63:0] i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q;
  logic [15:0] mem_d1;

  gpio_cmd_ctrl dut (
    .clk(clk), .i_resetn(i_resetn), .i_gpo(i_gpo), .o_gpi(o_gpi), .o_rst(o_rst),
    .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx), .o_phase_sel(o_phase_sel),
    .o_run_log(o_run_log), .o_read_log(o_read_log), .o_addr_log(o_addr_log),
    .i_mem_data(i_mem_data), .i_mem_full(i_mem_full),
    .i_ber_samp_i(i_ber_samp_i), .i_ber_samp_q(i_ber_samp_q),
    .i_ber_err_i(i_ber_err_i), .i_ber_err_q(i_ber_err_q)
  );

  always #5 clk = ~clk;

  // two-stage memory model: data valid two clocks after the address
  initial begin mem_d1 = 16'h0; i_mem_data = 16'h0; end
  always @(posedge clk) begin
    mem_d1     <= (o_addr_log == 15'h1234) ? 16'hBEEF : 16'h0000;
    i_mem_data <= mem_d1;
  end

  localparam int S_GPI = 0, S_RST = 1, S_TX = 2, S_RX = 3, S_PH = 4, S_RUN = 5, S_RD = 6, S_ADDR = 7;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t ent;
  int   cyc = 0;
  int   t0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] act(input int sel);
    case (sel)
      S_GPI:   return o_gpi;
      S_RST:   return 32'(o_rst);
      S_TX:    return 32'(o_enb_tx);
      S_RX:    return 32'(o_enb_rx);
      S_PH:    return 32'(o_phase_sel);
      S_RUN:   return 32'(o_run_log);
      S_RD:    return 32'(o_read_log);
      default: return 32'(o_addr_log);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      ent = sbq.pop_front();
      n_cmp++;
      if (ent.due < cyc) begin
        n_bad++;
        $display("FAIL %s: check missed at cycle %0d (due %0d)", ent.name, cyc, ent.due);
      end else if (act(ent.sel) !== ent.exp) begin
        n_bad++;
        $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", ent.name, cyc, act(ent.sel), ent.exp);
      end
    end
  end

  task automatic expect_at(input string nm, input int sel, input logic [31:0] v, input int due);
    exp_t e;
    int   i;
    e = '{due, sel, v, nm};
    i = sbq.size();
    while (i > 0 && sbq[i-1].due > due) i--;
    sbq.insert(i, e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [7:0] op, input logic [22:0] d);
    @(posedge clk); #1;
    t0 = cyc;
    i_gpo = {op, 1'b1, d};
  endtask

  task automatic drop();
    @(posedge clk); #1;
    i_gpo[23] = 1'b0;
  endtask

  int ta, tr;

  initial begin
    i_resetn = 1'b0;
    i_gpo = 32'h0;
    i_mem_full = 1'b0;
    i_ber_samp_i = 64'h0; i_ber_samp_q = 64'h0; i_ber_err_i = 64'h0; i_ber_err_q = 64'h0;
    wait_cyc(2);
    expect_at("rst_gpi", S_GPI, 32'h0, cyc);
    expect_at("rst_rst", S_RST, 32'h1, cyc);
    expect_at("rst_tx", S_TX, 32'h0, cyc);
    expect_at("rst_rx", S_RX, 32'h0, cyc);
    expect_at("rst_ph", S_PH, 32'h0, cyc);
    expect_at("rst_run", S_RUN, 32'h0, cyc);
    expect_at("rst_rd", S_RD, 32'h0, cyc);
    expect_at("rst_addr", S_ADDR, 32'h0, cyc);
    i_resetn = 1'b1;
    wait_cyc(1);

    strobe(8'd11, 23'h0);
    expect_at("berh_init", S_GPI, 32'h0, t0 + 1);
    expect_at("rst_hold", S_RST, 32'h1, t0 + 1);
    drop();

    strobe(8'd0, 23'h0);
    expect_at("rstpulse_last", S_RST, 32'h1, t0 + 4);
    expect_at("rstpulse_end", S_RST, 32'h0, t0 + 5);
    drop();
    wait_cyc(5);

    strobe(8'd1, 23'h1);
    expect_at("tx_before", S_TX, 32'h0, t0);
    expect_at("tx_on", S_TX, 32'h1, t0 + 1);
    drop();
    strobe(8'd2, 23'h1);
    expect_at("rx_on", S_RX, 32'h1, t0 + 1);
    drop();
    strobe(8'd3, 23'h2);
    expect_at("ph_2", S_PH, 32'h2, t0 + 1);
    drop();
    strobe(8'd3, 23'h7);
    expect_at("ph_7", S_PH, 32'h3, t0 + 1);
    drop();
    strobe(8'd5, 23'h1);
    expect_at("rd_on", S_RD, 32'h1, t0 + 1);
    drop();

    i_ber_samp_i = 64'h00000001_00000005;
    i_ber_samp_q = 64'h00000003_00000033;
    i_ber_err_i  = 64'h00000004_00000044;
    i_ber_err_q  = 64'h00000002_0000000A;
    strobe(8'd7, 23'h0);
    expect_at("ber_s_i", S_GPI, 32'h5, t0 + 1);
    drop();
    i_ber_samp_i = 64'hFFFFFFFF_FFFFFFFF;
    i_ber_err_q  = 64'h77777777_77777777;
    strobe(8'd10, 23'h0);
    expect_at("ber_e_q", S_GPI, 32'hA, t0 + 1);
    drop();
    strobe(8'd11, 23'h0);
    expect_at("ber_h_eq", S_GPI, 32'h2, t0 + 1);
    drop();
    strobe(8'd8, 23'h0);
    expect_at("ber_s_q", S_GPI, 32'h33, t0 + 1);
    drop();
    strobe(8'd11, 23'h0);
    expect_at("ber_h_sq", S_GPI, 32'h3, t0 + 1);
    drop();
    strobe(8'd9, 23'h0);
    expect_at("ber_e_i", S_GPI, 32'h44, t0 + 1);
    drop();

    i_mem_full = 1'b0;
    strobe(8'd12, 23'h0);
    expect_at("full_0", S_GPI, 32'h0, t0 + 1);
    drop();

    strobe(8'd4, 23'h0);
    expect_at("run_pre", S_RUN, 32'h0, t0);
    expect_at("run_hi", S_RUN, 32'h1, t0 + 1);
    expect_at("run_post", S_RUN, 32'h0, t0 + 2);
    drop();

    i_mem_full = 1'b1;
    strobe(8'd12, 23'h0);
    expect_at("full_1", S_GPI, 32'h1, t0 + 1);
    drop();

    strobe(8'd6, 23'h1234);
    ta = t0;
    expect_at("mem_addr", S_ADDR, 32'h1234, ta + 1);
    expect_at("mem_wait_gpi", S_GPI, 32'h1, ta + 3);
    expect_at("mem_data", S_GPI, 32'h0000BEEF, ta + 4);
    expect_at("mem_ignored_strobe", S_TX, 32'h1, ta + 6);
    drop();
    strobe(8'd1, 23'h0);
    drop();
    wait_cyc(4);

    strobe(8'd1, 23'h0);
    expect_at("held_first", S_TX, 32'h0, t0 + 1);
    wait_cyc(3);
    i_gpo[0] = 1'b1;
    expect_at("held_once", S_TX, 32'h0, t0 + 11);
    wait_cyc(7);
    drop();

    strobe(8'h55, 23'h7FFFFF);
    expect_at("bad_gpi", S_GPI, 32'h0000BEEF, t0 + 2);
    expect_at("bad_rx", S_RX, 32'h1, t0 + 2);
    expect_at("bad_ph", S_PH, 32'h3, t0 + 2);
    expect_at("bad_tx", S_TX, 32'h0, t0 + 2);
    expect_at("bad_rd", S_RD, 32'h1, t0 + 2);
    drop();
    wait_cyc(2);

    strobe(8'd0, 23'h0);
    expect_at("cmdrst_rst", S_RST, 32'h1, t0 + 1);
    expect_at("cmdrst_rx", S_RX, 32'h0, t0 + 1);
    expect_at("cmdrst_ph", S_PH, 32'h0, t0 + 1);
    expect_at("cmdrst_rd", S_RD, 32'h0, t0 + 1);
    expect_at("cmdrst_gpi", S_GPI, 32'h0000BEEF, t0 + 1);
    drop();
    wait_cyc(1);
    i_resetn = 1'b0;
    i_gpo = {8'd1, 1'b1, 23'h1};
    tr = cyc;
    expect_at("abort_gpi", S_GPI, 32'h0, tr + 1);
    expect_at("abort_addr", S_ADDR, 32'h0, tr + 1);
    expect_at("abort_rst", S_RST, 32'h1, tr + 1);
    wait_cyc(2);
    i_resetn = 1'b1;
    expect_at("held_thru_reset", S_TX, 32'h0, tr + 4);
    expect_at("held_thru_reset2", S_TX, 32'h0, tr + 5);
    wait_cyc(3);
    i_gpo[23] = 1'b0;
    wait_cyc(1);
    strobe(8'd1, 23'h1);
    expect_at("tx_after_reset", S_TX, 32'h1, t0 + 1);
    drop();
    strobe(8'd12, 23'h0);
    expect_at("full_after_reset", S_GPI, 32'h1, t0 + 1);
    drop();
    strobe(8'd11, 23'h0);
    expect_at("berh_after_reset", S_GPI, 32'h0, t0 + 1);
    drop();

    for (int k = 0; k < 40 && sbq.size() > 0; k++) wait_cyc(1);
    while (sbq.size() > 0) begin
      ent = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked (due %0d, now %0d)", ent.name, ent.due, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_cmd_ctrl.md
Name: gpio_cmd_ctrl

Overview:
- Command controller between the processor GPIO pair (i_gpo/o_gpi) and the Tx/Rx/BER/log-memory datapath.
- Detects command strobes, decodes 8-bit opcodes and drives the datapath control levels and pulses.
- Sequences log-memory reads and returns status, BER counts or memory words on o_gpi.

Parameters:
NB_GPIOS, 32, GPIO bus width (fixed 32 for field layout)
BRAM_ADDR_WIDTH, 15, log-memory address width
BRAM_DATA_WIDTH, 16, log-memory data width
NB_BER, 64, width of each BER counter
RST_CYCLES, 4, length of datapath reset pulse in clocks
MEM_LATENCY, 2, clocks from o_addr_log valid to i_mem_data valid (>=1)

Ports:
clk  in  1  system clock
i_resetn  in  1  synchronous active-low reset
i_gpo  in  32  command word: [31:24] opcode, [23] strobe, [22:0] data
o_gpi  out  32  readback word
o_rst  out  1  datapath reset
o_enb_tx  out  1  Tx enable level
o_enb_rx  out  1  Rx enable level
o_phase_sel  out  2  Rx filter phase
o_run_log  out  1  start-logging pulse
o_read_log  out  1  memory read-mode level
o_addr_log  out  BRAM_ADDR_WIDTH  log-memory read address
i_mem_data  in  BRAM_DATA_WIDTH  log-memory read data
i_mem_full  in  1  log memory full flag
i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q  in  NB_BER each  BER counters

Behaviour:
- Reset (i_resetn=0 at a clk edge):
  - o_gpi=0, o_rst=1, o_enb_tx=0, o_enb_rx=0, o_phase_sel=0, o_run_log=0, o_read_log=0, o_addr_log=0.
  - BER shadow regs=0, high-half reg=0, FSM=IDLE, strobe history=0.
- Strobe: a command executes on a 0->1 transition of i_gpo[23] (one registered copy).
  - Opcode and data are sampled in the same cycle as the transition.
  - A strobe held high executes once.
- FSM states: IDLE, RST_PULSE, MEM_WAIT.
  - Edges detected outside IDLE are discarded; the history register still tracks i_gpo[23].
- Opcodes (decoded in IDLE). Levels and o_gpi update on the clock after the edge.
  - 0 RESET: o_rst=1 for exactly RST_CYCLES clocks, then 0; state RST_PULSE; o_enb_tx, o_enb_rx, o_phase_sel, o_read_log cleared to 0; o_gpi unchanged.
  - 1 EN_TX: o_enb_tx=data[0].
  - 2 EN_RX: o_enb_rx=data[0].
  - 3 PH_SEL: o_phase_sel=data[1:0].
  - 4 RUN_MEM: o_run_log=1 for exactly one clock.
  - 5 READ_MEM: o_read_log=data[0].
  - 6 ADDR_MEM: o_addr_log=data[BRAM_ADDR_WIDTH-1:0]; state MEM_WAIT for MEM_LATENCY clocks; then o_gpi={zero-ext, i_mem_data}; back to IDLE. Executes regardless of o_read_log.
  - 7 BER_S_I: snapshot all four counters into shadow in one clock; o_gpi=shadow_samp_i[31:0]; high reg=shadow_samp_i[63:32].
  - 8 BER_S_Q, 9 BER_E_I, 10 BER_E_Q: no new snapshot; o_gpi=low 32 bits of the matching shadow; high reg=its upper 32 bits.
  - 11 BER_H: o_gpi=high reg (0 if no BER read since reset).
  - 12 IS_MEM_FULL: o_gpi={31'b0, i_mem_full} sampled the clock after the edge.
  - Any other opcode: no effect, o_gpi unchanged.
- o_rst is high only from reset or RESET; RESET does not clear o_gpi or BER shadows.
- Reset mid-operation: i_resetn low in RST_PULSE or MEM_WAIT aborts to IDLE with reset values.
  - A strobe already high when reset releases does not execute (history loads i_gpo[23] on the first clock after reset).
- o_gpi holds its last value until the next readback-type opcode completes.

Test Plan:
- Reset, then RESET strobe -> o_rst high 4 clocks after the edge, then low; next EN_TX strobe accepted.
- EN_TX data=1, EN_RX data=1, PH_SEL data=2 -> o_enb_tx=1, o_enb_rx=1, o_phase_sel=2, each one clock after its edge; PH_SEL data=7 -> o_phase_sel=3.
- Counters samp_i=0x00000001_00000005, err_q=0x2_0000000A; BER_S_I, then change inputs, then BER_E_Q, BER_H:
  - o_gpi=0x5, then 0xA (snapshot value), then 0x2.
- IS_MEM_FULL with i_mem_full=0 -> o_gpi=0.
- RUN_MEM -> o_run_log exactly one clock high.
- Raise i_mem_full, IS_MEM_FULL -> o_gpi=1.
- ADDR_MEM data=0x1234, model returns 0xBEEF after 2 clocks -> o_addr_log=0x1234, o_gpi=0x0000BEEF after MEM_LATENCY+1 clocks.
  - Second strobe during MEM_WAIT is ignored.
- Strobe held high 10 clocks with opcode EN_TX -> single execution.
- Opcode 0x55 -> no output change.
- i_resetn low during RST_PULSE -> all outputs at reset values next clock.
